// File: rtl/tcp_retx_scheduler.sv
// Retransmission-timeout scheduler: one RTO timer per port, a pending set of expired
// ports, and round-robin sharing of a single retransmit engine.
`timescale 1ns/1ps
module tcp_retx_scheduler #(
  parameter int PORT_NUM  = 4,
  parameter int TIMER_W   = 16,
  parameter int MAX_RETRY = 3,
  localparam int PW = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1,
  localparam int RW = $clog2(MAX_RETRY + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tick_i,
  input  logic [TIMER_W-1:0]  rto_i,
  input  logic [PORT_NUM-1:0] unack_i,
  input  logic [PORT_NUM-1:0] ack_i,
  output logic                retx_req_o,
  output logic [PW-1:0]       retx_port_o,
  input  logic                retx_ack_i,
  input  logic                retx_done_i,
  output logic [PORT_NUM-1:0] pend_o,
  output logic [PORT_NUM-1:0] abort_o,
  output logic                busy_o
);

  typedef enum logic [1:0] {IDLE, REQ, SERV} state_t;

  state_t              state, state_nxt;
  logic [TIMER_W-1:0]  timer [PORT_NUM];
  logic [RW-1:0]       retry [PORT_NUM];
  logic [PORT_NUM-1:0] pend, abort_q;
  logic [PORT_NUM-1:0] in_serv, hold, expire, done_p, withdraw;
  logic [PW-1:0]       last_port, port_q, sel_port;
  logic                sel_found;
  logic [TIMER_W-1:0]  rto_eff;

  assign rto_eff     = (rto_i == '0) ? TIMER_W'(1) : rto_i;
  assign retx_req_o  = (state == REQ);
  assign busy_o      = (state != IDLE);
  assign retx_port_o = port_q;
  assign pend_o      = pend;
  assign abort_o     = abort_q;

  // Using >= lets a timer that overshot a freshly lowered rto_i expire on its next tick.
  always_comb begin
    in_serv  = '0;
    hold     = '0;
    expire   = '0;
    done_p   = '0;
    withdraw = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      in_serv[p]  = (state == SERV) && (port_q == PW'(p));
      hold[p]     = !unack_i[p] || ack_i[p] || pend[p] || in_serv[p];
      expire[p]   = tick_i && !hold[p] && (timer[p] >= rto_eff - TIMER_W'(1));
      done_p[p]   = in_serv[p] && retx_done_i;
      withdraw[p] = (ack_i[p] || !unack_i[p]) && !in_serv[p];
    end
  end

  always_comb begin
    sel_found = 1'b0;
    sel_port  = last_port;
    for (int i = 1; i <= PORT_NUM; i++) begin
      if (!sel_found && pend[(int'(last_port) + i) % PORT_NUM]) begin
        sel_found = 1'b1;
        sel_port  = PW'((int'(last_port) + i) % PORT_NUM);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (sel_found) state_nxt = REQ;
      REQ: begin
        if (retx_ack_i)
          state_nxt = SERV;
        else if (!pend[port_q] || ack_i[port_q] || !unack_i[port_q])
          state_nxt = IDLE;
      end
      SERV: if (retx_done_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      last_port <= PW'(PORT_NUM - 1);
      port_q    <= '0;
      pend      <= '0;
      abort_q   <= '0;
      for (int p = 0; p < PORT_NUM; p++) begin
        timer[p] <= '0;
        retry[p] <= '0;
      end
    end else begin
      state <= state_nxt;
      if (state == IDLE && sel_found) begin
        port_q    <= sel_port;
        last_port <= sel_port;
      end
      for (int p = 0; p < PORT_NUM; p++) begin
        if (hold[p] || expire[p])
          timer[p] <= '0;
        else if (tick_i)
          timer[p] <= timer[p] + TIMER_W'(1);

        if (done_p[p] || withdraw[p])
          pend[p] <= 1'b0;
        else if (expire[p] && retry[p] < RW'(MAX_RETRY))
          pend[p] <= 1'b1;

        abort_q[p] <= expire[p] && (retry[p] >= RW'(MAX_RETRY));

        // A fresh ACK always wins, even against a coincident done.
        if (ack_i[p])
          retry[p] <= '0;
        else if (done_p[p]) begin
          if (retry[p] < RW'(MAX_RETRY))
            retry[p] <= retry[p] + RW'(1);
        end else if (expire[p] && retry[p] >= RW'(MAX_RETRY))
          retry[p] <= '0;
      end
    end
  end

endmodule

// File: doc/tcp_retx_scheduler.md
Name: tcp_retx_scheduler

Overview:
- Per-connection retransmission-timeout scheduler for the multi-port TCP transmit path.
- Runs one RTO timer per port for ports holding unconfirmed data.
- Queues expired ports and shares the single retransmit engine between them by round-robin with a req/ack/done handshake.
- Counts retries per port and raises an abort pulse once the retry limit is exhausted.

Parameters:
PORT_NUM, 4, number of TCP connections/ports.
TIMER_W, 16, width of RTO timers and rto_i.
MAX_RETRY, 3, retransmissions allowed before abort (>=1).
PW, derived = ceil(log2(PORT_NUM)) (minimum 1), port index width; not user-set.

Ports:
clk  in  1  system clock.
rst  in  1  synchronous active-high reset.
tick_i  in  1  timebase strobe; timers advance only on cycles with tick_i=1.
rto_i  in  TIMER_W  timeout in ticks, shared by all ports; 0 is treated as 1.
unack_i  in  PORT_NUM  level; port p has unconfirmed data in memory.
ack_i  in  PORT_NUM  1-cycle pulse; new ACK advanced port p's window.
retx_req_o  out  1  retransmit request to the tx engine.
retx_port_o  out  PW  port index being requested or serviced.
retx_ack_i  in  1  tx engine accepted the request (sampled only in REQ).
retx_done_i  in  1  retransmission finished (sampled only in SERV).
pend_o  out  PORT_NUM  expired ports awaiting service.
abort_o  out  PORT_NUM  1-cycle pulse; port p exceeded MAX_RETRY.
busy_o  out  1  FSM is in REQ or SERV.

Behaviour:
- Reset: all outputs 0; all timers, retry counters and pend flags cleared; FSM=IDLE; last_port=PORT_NUM-1, so port 0 has first priority.
- Per-port timer:
  - Clears to 0 when unack_i[p]=0, ack_i[p]=1, pend[p]=1, or p is in service.
  - Otherwise increments on tick_i.
  - Expiry occurs on a tick when timer==max(rto_i,1)-1.
  - On expiry: if retry[p]<MAX_RETRY, set pend[p] next cycle; else pulse abort_o[p] next cycle, clear retry[p], leave pend[p]=0.
- Priority: ack_i[p] in the same cycle as expiry wins; no pend, timer to 0.
- pend[p] clear conditions:
  - retx_done_i for p in SERV;
  - ack_i[p]=1 or unack_i[p]=0 while p is not in SERV.
- retry[p]:
  - Increments by 1 on done for p.
  - Clears on ack_i[p] at any time, including during SERV.
  - If done and ack_i[p] coincide, the result is 0.
  - Saturates at MAX_RETRY; width ceil(log2(MAX_RETRY+1)).
- FSM IDLE:
  - If any pend is set, select the first set port scanning last_port+1 upward with wrap.
  - Register it to retx_port_o and last_port, then go to REQ.
  - retx_port_o holds its last value in IDLE.
- FSM REQ:
  - retx_req_o=1, retx_port_o stable.
  - If retx_ack_i=1, go to SERV; retx_req_o drops in the same transition.
  - Else if pend[port] cleared (ack/unack withdrawal), drop req and return to IDLE with no retry change.
  - Ack has priority over withdrawal in the same cycle.
- FSM SERV:
  - Wait for retx_done_i; the port's timer is held at 0 throughout.
  - ack_i or unack_i withdrawal in SERV do not abort service.
  - On done: clear pend, update retry, go to IDLE. The timer restarts from 0 next cycle if unack_i is still 1.
- Latency: expiry tick at cycle N gives pend_o at N+1, retx_req_o at N+2 (FSM idle). Minimum of 1 idle cycle between consecutive grants.
- rto_i changes take effect at the next comparison; a timer already >= rto_i expires on its next tick.
- busy_o=1 exactly in REQ or SERV.
- Reset asserted mid-operation returns everything to reset state next cycle; req drops immediately after the reset edge.

Test Plan:
- PORT_NUM=4, rto_i=5, unack_i[1]=1, tick_i every cycle: pend_o=4'b0010 one cycle after the 5th tick, then retx_req_o=1 with retx_port_o=1; ack then done clears pend and timer restarts.
- Ports 0,2,3 expire together: grants issued in order 0,2,3, each held until ack+done; next round after port 3 starts at port 0.
- MAX_RETRY=3, port 2 never acked: 3 retransmissions complete; on the 4th expiry abort_o=4'b0100 for exactly one cycle, no request issued, retry reset.
- Port 1 in REQ, ack_i[1] pulse before retx_ack_i: retx_req_o drops next cycle, pend_o[1]=0, FSM returns to IDLE, no retry increment.
- ack_i[0] coincident with port 0 expiry tick: no pend, timer=0. retx_done_i and ack_i coincident in SERV: retry=0.
- rst asserted while in SERV: next cycle busy_o=0, retx_req_o=0, pend_o=0, abort_o=0; the first grant after reset goes to port 0.
